// File: rtl/aes_pkg.sv
// AES shared definitions: FSM states, GF(2^8) arithmetic, S-box, Rcon and round-count helper.
package aes_pkg;

  typedef enum logic [2:0] {KEY_EMPTY, KEY_EXP, IDLE, ROUND, DONE} aes_state_e;

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 (product of x^2..x^128), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] sb [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_in[127-8*i -: 8]);
  end

  // Byte i sits at column i/4, row i%4; row r of column c comes from column (c+r)%4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] sr, mc;
    assign a0 = sb[4*c];
    assign a1 = sb[4*((c+1)%4)+1];
    assign a2 = sb[4*((c+2)%4)+2];
    assign a3 = sb[4*((c+3)%4)+3];
    assign sr = {a0, a1, a2, a3};
    assign mc = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    assign state_out[127-32*c -: 32] = (last ? sr : mc) ^ round_key[127-32*c -: 32];
  end

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128/192/256 encryptor: one key word per cycle, one round per cycle.
// Define AES_BLK_CNT_EN to add the blk_cnt output-handshake counter.
module aes_enc_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                key_ready,
  input  logic                in_valid,
  input  logic [127:0]        in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [127:0]        out_data,
  input  logic                out_ready
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]         blk_cnt
`endif
);

  localparam int NK   = KEY_BITS / 32;
  localparam int NR   = nr_of(KEY_BITS);
  localparam int NW   = 4 * (NR + 1);
  localparam int WIDX = $clog2(NW);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_enc_core: KEY_BITS must be 128, 192 or 256");
  end

  aes_state_e      fsm;
  logic [31:0]     w [NW];
  logic [WIDX-1:0] wcnt;
  logic [2:0]      kpos;
  logic [3:0]      rcnt;
  logic [3:0]      rnd;
  logic [127:0]    st;

  logic            key_take;
  logic [31:0]     temp, sched, new_word;
  logic [WIDX-1:0] rk_base;
  logic [127:0]    rk, rk0, rnd_out;
  logic            last;

  assign key_take = key_valid && key_ready;

  // kpos tracks i mod Nk so no divider is needed in the schedule.
  always_comb begin
    temp = w[wcnt - WIDX'(1)];
    if (kpos == 3'd0)
      sched = sub_word({temp[23:0], temp[31:24]}) ^ {rcon(rcnt), 24'h0};
    else if (NK == 8 && kpos == 3'd4)
      sched = sub_word(temp);
    else
      sched = temp;
    new_word = w[wcnt - WIDX'(NK)] ^ sched;
  end

  assign rk_base = {rnd[WIDX-3:0], 2'b00};
  assign rk      = {w[rk_base], w[rk_base | WIDX'(1)], w[rk_base | WIDX'(2)], w[rk_base | WIDX'(3)]};
  assign rk0     = {w[0], w[1], w[2], w[3]};
  assign last    = (rnd == 4'(NR));

  aes_round u_round (
    .state_in  (st),
    .round_key (rk),
    .last      (last),
    .state_out (rnd_out)
  );

  // The store needs no reset: the FSM refuses blocks until a fresh expansion completes.
  always_ff @(posedge clk) begin
    if (key_take) begin
      for (int j = 0; j < NK; j++)
        w[j] <= key_in[KEY_BITS-1-32*j -: 32];
    end else if (fsm == KEY_EXP) begin
      w[wcnt] <= new_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= KEY_EMPTY;
      key_ready <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      wcnt      <= '0;
      kpos      <= '0;
      rcnt      <= '0;
      rnd       <= '0;
      st        <= '0;
    end else begin
      case (fsm)
        KEY_EMPTY, IDLE: begin
          if (key_valid) begin
            fsm       <= KEY_EXP;
            key_ready <= 1'b0;
            in_ready  <= 1'b0;
            wcnt      <= WIDX'(NK);
            kpos      <= '0;
            rcnt      <= 4'd1;
          end else if (in_valid && fsm == IDLE) begin
            fsm       <= ROUND;
            key_ready <= 1'b0;
            in_ready  <= 1'b0;
            st        <= in_data ^ rk0;
            rnd       <= 4'd1;
          end
        end
        KEY_EXP: begin
          wcnt <= wcnt + WIDX'(1);
          kpos <= (kpos == 3'(NK-1)) ? 3'd0 : kpos + 3'd1;
          if (kpos == 3'd0) rcnt <= rcnt + 4'd1;
          if (wcnt == WIDX'(NW-1)) begin
            fsm       <= IDLE;
            key_ready <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ROUND: begin
          st <= rnd_out;
          if (last) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            key_ready <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        default: fsm <= KEY_EMPTY;
      endcase
    end
  end

  assign out_data = out_valid ? st : '0;

`ifdef AES_BLK_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         blk_cnt <= '0;
    else if (key_take)               blk_cnt <= '0;
    else if (out_valid && out_ready) blk_cnt <= blk_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_aes_enc_core.sv
// Directed-vector bench for aes_enc_core: one instance per key size, selected by sel.
module tb_aes_enc_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         kv = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic [255:0] kin = '0;
  logic [127:0] din = '0;
  int           sel = 0;
  int           vec = 0;
  int           errs = 0;

  logic [2:0]   kr, ir, ov;
  logic [127:0] od0, od1, od2;
  logic         c_kr, c_ir, c_ov;
  logic [127:0] c_od;
`ifdef AES_BLK_CNT_EN
  logic [31:0]  bc0, bc1, bc2;
`endif

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT2   = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_enc_core #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .key_valid(kv && sel == 0), .key_in(kin[255 -: 128]), .key_ready(kr[0]),
    .in_valid(iv && sel == 0), .in_data(din), .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od0),
    .out_ready(ordy)
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(bc0)
`endif
  );
  aes_enc_core #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .key_valid(kv && sel == 1), .key_in(kin[255 -: 192]), .key_ready(kr[1]),
    .in_valid(iv && sel == 1), .in_data(din), .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od1),
    .out_ready(ordy)
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(bc1)
`endif
  );
  aes_enc_core #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .key_valid(kv && sel == 2), .key_in(kin), .key_ready(kr[2]),
    .in_valid(iv && sel == 2), .in_data(din), .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od2),
    .out_ready(ordy)
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(bc2)
`endif
  );

  always_comb begin
    c_kr = kr[0]; c_ir = ir[0]; c_ov = ov[0]; c_od = od0;
    case (sel)
      1: begin c_kr = kr[1]; c_ir = ir[1]; c_ov = ov[1]; c_od = od1; end
      2: begin c_kr = kr[2]; c_ir = ir[2]; c_ov = ov[2]; c_od = od2; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int s, input logic [255:0] k, output int n);
    sel = s; kin = k; kv = 1'b1;
    tick();
    kv = 1'b0; n = 0;
    while (!c_kr && n < 200) begin tick(); n++; end
  endtask

  task automatic run_block(input logic [127:0] pt, output logic [127:0] ct, output int n);
    din = pt; iv = 1'b1;
    tick();
    iv = 1'b0; n = 0;
    while (!c_ov && n < 100) begin tick(); n++; end
    ct = c_od;
  endtask

  task automatic handshake();
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1;
    repeat (3) tick();
    vec++;
    if ({kr, ir, ov} !== 9'b111_000_000) begin
      errs++; $display("FAIL reset_flags: got kr=%b ir=%b ov=%b expected kr=111 ir=000 ov=000", kr, ir, ov);
    end
    vec++;
    if ({od0, od1, od2} !== '0) begin
      errs++; $display("FAIL reset_out_data: got %h expected 0", od0);
    end
    rst = 1'b0;
    sel = 0; iv = 1'b1; din = PT; seen = 1'b0;
    repeat (20) begin tick(); seen |= c_ov | c_ir; end
    iv = 1'b0;
    vec++;
    if (seen !== 1'b0 || c_kr !== 1'b1) begin
      errs++; $display("FAIL key_empty_ignores_block: got seen=%b kr=%b expected seen=0 kr=1", seen, c_kr);
    end
  endtask

  task automatic test_size(input int s, input logic [255:0] k, input int exp_n, input int nr,
                           input logic [127:0] exp_ct);
    int n;
    logic [127:0] ct;
    load_key(s, k, n);
    vec++;
    if (n !== exp_n) begin
      errs++; $display("FAIL expand_cycles_%0d: got %0d expected %0d", s, n, exp_n);
    end
    run_block(PT, ct, n);
    vec++;
    if (ct !== exp_ct) begin
      errs++; $display("FAIL ciphertext_%0d: got %h expected %h", s, ct, exp_ct);
    end
    vec++;
    if (n !== nr) begin
      errs++; $display("FAIL latency_%0d: got %0d expected %0d", s, n, nr);
    end
    handshake();
    vec++;
    if (c_ov !== 1'b0 || c_od !== '0 || c_ir !== 1'b1) begin
      errs++; $display("FAIL post_handshake_%0d: got ov=%b od=%h ir=%b expected ov=0 od=0 ir=1", s, c_ov, c_od, c_ir);
    end
  endtask

  task automatic test_hold();
    int n;
    logic [127:0] ct;
    logic bad;
    load_key(0, KFIPS, n);
    run_block(PT2, ct, n);
    vec++;
    if (ct !== CT2) begin
      errs++; $display("FAIL fips_ciphertext: got %h expected %h", ct, CT2);
    end
    // A key offered while DONE must be ignored.
    bad = 1'b0; kin = K128; kv = 1'b1;
    repeat (5) begin
      tick();
      if (c_od !== CT2 || c_ir !== 1'b0 || c_ov !== 1'b1) bad = 1'b1;
    end
    kv = 1'b0;
    vec++;
    if (bad !== 1'b0) begin
      errs++; $display("FAIL hold_stable: got od=%h ir=%b ov=%b expected od=%h ir=0 ov=1", c_od, c_ir, c_ov, CT2);
    end
    handshake();
    run_block(PT2, ct, n);
    vec++;
    if (ct !== CT2) begin
      errs++; $display("FAIL key_retained: got %h expected %h", ct, CT2);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [127:0] ct;
    load_key(0, K128, n);
    for (int b = 0; b < 3; b++) begin
      run_block(PT, ct, n);
      vec++;
      if (ct !== CT128 || n !== 10) begin
        errs++; $display("FAIL b2b_block%0d: got ct=%h lat=%0d expected ct=%h lat=10", b, ct, n, CT128);
      end
      handshake();
    end
`ifdef AES_BLK_CNT_EN
    vec++;
    if (bc0 !== 32'd3) begin
      errs++; $display("FAIL blk_cnt_three: got %0d expected 3", bc0);
    end
    load_key(0, KFIPS, n);
    vec++;
    if (bc0 !== 32'd0) begin
      errs++; $display("FAIL blk_cnt_clear: got %0d expected 0", bc0);
    end
`endif
  endtask

  task automatic test_collide_reset();
    int n;
    logic [127:0] ct;
    logic seen;
    sel = 0; kin = K128; kv = 1'b1; din = PT2; iv = 1'b1;
    tick();
    kv = 1'b0; iv = 1'b0;
    vec++;
    if (c_kr !== 1'b0 || c_ir !== 1'b0) begin
      errs++; $display("FAIL collide_key_taken: got kr=%b ir=%b expected kr=0 ir=0", c_kr, c_ir);
    end
    n = 0; seen = 1'b0;
    while (!c_kr && n < 200) begin tick(); n++; seen |= c_ov; end
    vec++;
    if (n !== 40 || seen !== 1'b0) begin
      errs++; $display("FAIL collide_no_block: got n=%0d ov_seen=%b expected n=40 ov_seen=0", n, seen);
    end
    run_block(PT, ct, n);
    vec++;
    if (ct !== CT128) begin
      errs++; $display("FAIL collide_new_key: got %h expected %h", ct, CT128);
    end
    handshake();
    din = PT; iv = 1'b1;
    tick();
    iv = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if (c_ov !== 1'b0 || c_kr !== 1'b1 || c_ir !== 1'b0 || c_od !== '0) begin
      errs++; $display("FAIL mid_round_reset: got ov=%b kr=%b ir=%b od=%h expected ov=0 kr=1 ir=0 od=0", c_ov, c_kr, c_ir, c_od);
    end
    iv = 1'b1; seen = 1'b0;
    repeat (20) begin tick(); seen |= c_ov | c_ir; end
    iv = 1'b0;
    vec++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL post_reset_ignores_block: got seen=%b expected 0", seen);
    end
    load_key(0, K128, n);
    run_block(PT, ct, n);
    vec++;
    if (ct !== CT128 || n !== 10) begin
      errs++; $display("FAIL post_reset_reload: got ct=%h lat=%0d expected ct=%h lat=10", ct, n, CT128);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_size(0, K128, 40, 10, CT128);
    test_size(1, K192, 46, 12, CT192);
    test_size(2, K256, 52, 14, CT256);
    test_hold();
    test_back_to_back();
    test_collide_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
